// File: rtl/muldiv_pkg.sv
// Shared op-bit indices, FSM encoding and op-classification helpers for the M-extension unit.
// Latency: none (declarations only).
// Backpressure: not applicable.
package muldiv_pkg;

  localparam int OP_W      = 13;
  localparam int OP_MUL    = 12;
  localparam int OP_MULH   = 11;
  localparam int OP_MULHSU = 10;
  localparam int OP_MULHU  = 9;
  localparam int OP_DIV    = 8;
  localparam int OP_DIVU   = 7;
  localparam int OP_REM    = 6;
  localparam int OP_REMU   = 5;
  localparam int OP_MULW   = 4;
  localparam int OP_DIVW   = 3;
  localparam int OP_DIVUW  = 2;
  localparam int OP_REMW   = 1;
  localparam int OP_REMUW  = 0;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_PREP = 3'd1,
    ST_CALC = 3'd2,
    ST_FIX  = 3'd3,
    ST_DONE = 3'd4
  } state_t;

  function automatic logic is_mul(input logic [OP_W-1:0] op);
    return op[OP_MUL] | op[OP_MULH] | op[OP_MULHSU] | op[OP_MULHU] | op[OP_MULW];
  endfunction

  // mul/mulw are treated as signed: the low half of the product is the same either way.
  function automatic logic is_signed_a(input logic [OP_W-1:0] op);
    return op[OP_MUL] | op[OP_MULH] | op[OP_MULHSU] | op[OP_DIV] | op[OP_REM] |
           op[OP_MULW] | op[OP_DIVW] | op[OP_REMW];
  endfunction

  function automatic logic is_signed_b(input logic [OP_W-1:0] op);
    return op[OP_MUL] | op[OP_MULH] | op[OP_DIV] | op[OP_REM] |
           op[OP_MULW] | op[OP_DIVW] | op[OP_REMW];
  endfunction

  function automatic logic is_word(input logic [OP_W-1:0] op);
    return op[OP_MULW] | op[OP_DIVW] | op[OP_DIVUW] | op[OP_REMW] | op[OP_REMUW];
  endfunction

  function automatic logic want_high(input logic [OP_W-1:0] op);
    return op[OP_MULH] | op[OP_MULHSU] | op[OP_MULHU];
  endfunction

  function automatic logic want_rem(input logic [OP_W-1:0] op);
    return op[OP_REM] | op[OP_REMU] | op[OP_REMW] | op[OP_REMUW];
  endfunction

endpackage

// File: rtl/muldiv_special.sv
// Flags requests that bypass iteration (div-by-zero, signed overflow, illegal op) and forms their result.
// Latency: combinational.
// Backpressure: none; evaluated on the raw request operands.
module muldiv_special
  import muldiv_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic [OP_W-1:0] op,
  input  logic [XLEN-1:0] src1,
  input  logic [XLEN-1:0] src2,
  output logic            hit,
  output logic [XLEN-1:0] result
);

  localparam int HALF = XLEN / 2;

  logic            word;
  logic            illegal;
  logic            is_div;
  logic            div_zero;
  logic            sdiv_ovf;
  logic [XLEN-1:0] dividend_w;

  // Classify the request and build the bypass result at operating width (W results sign-extended)
  always_comb begin
    word       = is_word(op);
    illegal    = (op == '0) || ((op & (op - OP_W'(1))) != '0);
    is_div     = !is_mul(op);
    dividend_w = word ? {{HALF{src1[HALF-1]}}, src1[HALF-1:0]} : src1;
    div_zero   = is_div && (word ? (src2[HALF-1:0] == '0) : (src2 == '0));
    sdiv_ovf   = is_div && is_signed_a(op) &&
                 (word ? ((src1[HALF-1:0] == {1'b1, {(HALF-1){1'b0}}}) && (src2[HALF-1:0] == '1))
                       : ((src1 == {1'b1, {(XLEN-1){1'b0}}}) && (src2 == '1)));
    hit        = illegal || div_zero || sdiv_ovf;
    result     = '0;
    if (illegal) begin
      result = '0;
    end else if (div_zero) begin
      result = want_rem(op) ? dividend_w : '1;
    end else if (sdiv_ovf) begin
      result = want_rem(op) ? '0 : dividend_w;
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV64M multiply/divide: sign-magnitude shift-add multiply and restoring divide, 1 bit/cycle.
// Latency: out_valid rises N+2 edges after the fire edge (N=XLEN, or XLEN/2 for W-ops); bypass cases at the fire edge.
// Backpressure: result held in DONE until out_ready; in_ready only in IDLE without flush.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [OP_W-1:0] in_op,
  input  logic [XLEN-1:0] in_src1,
  input  logic [XLEN-1:0] in_src2,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_result,
  output logic            busy
);

  localparam int HALF  = XLEN / 2;
  localparam int CNT_W = $clog2(XLEN) + 1;

  state_t            state, state_nxt;
  logic [OP_W-1:0]   op_q;
  logic [XLEN-1:0]   src1_q, src2_q, opnd_q;
  logic [2*XLEN-1:0] acc_q;
  logic              neg_q, neg_rem_q;
  logic [CNT_W-1:0]  cnt_q;

  logic              fire;
  logic              spec_hit;
  logic [XLEN-1:0]   spec_res;

  // operand preparation
  logic [XLEN-1:0]   a_ext, b_ext, mag_a, mag_b;
  logic              a_neg, b_neg;
  // iteration step
  logic [XLEN:0]     mul_sum, div_hi, div_sub;
  logic              div_ge;
  logic [2*XLEN-1:0] step_nxt;
  // final fix-up
  logic [2*XLEN-1:0] prod, prod_s;
  logic [XLEN-1:0]   quo_s, rem_s, fix_raw, fix_res;

  assign in_ready  = (state == ST_IDLE) && !flush;
  assign fire      = in_valid && in_ready;
  assign out_valid = (state == ST_DONE);
  assign busy      = (state != ST_IDLE);

  muldiv_special #(.XLEN(XLEN)) u_special (
    .op     (in_op),
    .src1   (in_src1),
    .src2   (in_src2),
    .hit    (spec_hit),
    .result (spec_res)
  );

  // Extend operands to operating width and split into magnitude plus sign
  always_comb begin
    a_ext = src1_q;
    b_ext = src2_q;
    if (is_word(op_q)) begin
      a_ext = is_signed_a(op_q) ? {{HALF{src1_q[HALF-1]}}, src1_q[HALF-1:0]} : {{HALF{1'b0}}, src1_q[HALF-1:0]};
      b_ext = is_signed_b(op_q) ? {{HALF{src2_q[HALF-1]}}, src2_q[HALF-1:0]} : {{HALF{1'b0}}, src2_q[HALF-1:0]};
    end
    a_neg = is_signed_a(op_q) && a_ext[XLEN-1];
    b_neg = is_signed_b(op_q) && b_ext[XLEN-1];
    mag_a = a_neg ? -a_ext : a_ext;
    mag_b = b_neg ? -b_ext : b_ext;
  end

  // One iteration: multiply adds into the upper half then shifts right; divide shifts left and trial-subtracts
  always_comb begin
    mul_sum = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    div_hi  = acc_q[2*XLEN-1:XLEN-1];
    div_ge  = (div_hi >= {1'b0, opnd_q});
    div_sub = div_hi - {1'b0, opnd_q};
    if (is_mul(op_q)) begin
      step_nxt = {mul_sum, acc_q[XLEN-1:1]};
    end else begin
      step_nxt = {(div_ge ? div_sub[XLEN-1:0] : div_hi[XLEN-1:0]), acc_q[XLEN-2:0], div_ge};
    end
  end

  // Apply the sign, pick the wanted half, sign-extend W results
  always_comb begin
    prod    = is_word(op_q) ? (acc_q >> HALF) : acc_q;
    prod_s  = neg_q ? -prod : prod;
    quo_s   = neg_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
    rem_s   = neg_rem_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
    fix_raw = want_rem(op_q) ? rem_s : quo_s;
    if (is_mul(op_q)) begin
      fix_raw = want_high(op_q) ? prod_s[2*XLEN-1:XLEN] : prod_s[XLEN-1:0];
    end
    fix_res = is_word(op_q) ? {{HALF{fix_raw[HALF-1]}}, fix_raw[HALF-1:0]} : fix_raw;
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic; flush overrides every transition
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (fire) state_nxt = spec_hit ? ST_DONE : ST_PREP;
      ST_PREP: state_nxt = ST_CALC;
      ST_CALC: if (cnt_q == '0) state_nxt = ST_FIX;
      ST_FIX:  state_nxt = ST_DONE;
      ST_DONE: if (out_ready) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
    if (flush) state_nxt = ST_IDLE;
  end

  // Datapath registers: capture on fire, seed in PREP, iterate in CALC, publish in FIX
  always_ff @(posedge clk) begin
    if (rst) begin
      op_q       <= '0;
      src1_q     <= '0;
      src2_q     <= '0;
      opnd_q     <= '0;
      acc_q      <= '0;
      neg_q      <= 1'b0;
      neg_rem_q  <= 1'b0;
      cnt_q      <= '0;
      out_result <= '0;
    end else begin
      case (state)
        ST_IDLE: if (fire) begin
          op_q   <= in_op;
          src1_q <= in_src1;
          src2_q <= in_src2;
          if (spec_hit) out_result <= spec_res;
        end
        ST_PREP: begin
          neg_q     <= a_neg ^ b_neg;
          neg_rem_q <= a_neg;
          cnt_q     <= is_word(op_q) ? CNT_W'(HALF - 1) : CNT_W'(XLEN - 1);
          if (is_mul(op_q)) begin
            opnd_q <= mag_a;
            acc_q  <= {{XLEN{1'b0}}, mag_b};
          end else begin
            // W dividends start in the upper half so HALF shifts bring them fully through
            opnd_q <= mag_b;
            acc_q  <= {{XLEN{1'b0}}, (is_word(op_q) ? {mag_a[HALF-1:0], {HALF{1'b0}}} : mag_a)};
          end
        end
        ST_CALC: begin
          acc_q <= step_nxt;
          if (cnt_q != '0) cnt_q <= cnt_q - CNT_W'(1);
        end
        ST_FIX:  out_result <= fix_res;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Randomized and directed checks of muldiv_unit against a plain-arithmetic reference model.
// Latency: measured as edges after the fire edge until out_valid is seen.
// Backpressure: out_ready driven by the bench; stability checked while stalled.
module tb_muldiv_unit;
  import muldiv_pkg::*;

  localparam logic [63:0] MIN64 = 64'h8000_0000_0000_0000;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, in_ready, out_valid, out_ready, busy;
  logic [12:0] in_op;
  logic [63:0] in_src1, in_src2, out_result;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  muldiv_unit #(.XLEN(64)) dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_op      (in_op),
    .in_src1    (in_src1),
    .in_src2    (in_src2),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .busy       (busy)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=0x%016h exp=0x%016h", tag, got, exp);
    end
  endtask

  function automatic logic [12:0] opv(input int idx);
    return 13'd1 << idx;
  endfunction

  function automatic logic [63:0] sx32(input logic [31:0] v);
    return {{32{v[31]}}, v};
  endfunction

  // Reference result straight from the arithmetic definitions of each instruction
  function automatic logic [63:0] ref_result(input logic [12:0] op, input logic [63:0] a, input logic [63:0] b);
    logic [127:0]      p_ss, p_su, p_uu;
    logic [31:0]       a32, b32, t;
    logic signed [63:0] sa, sb;
    logic signed [31:0] sa32, sb32;
    logic [63:0]       r;
    a32 = a[31:0];  b32 = b[31:0];
    sa  = a;        sb  = b;
    sa32 = a32;     sb32 = b32;
    p_ss = {{64{a[63]}}, a} * {{64{b[63]}}, b};
    p_su = {{64{a[63]}}, a} * {64'd0, b};
    p_uu = {64'd0, a} * {64'd0, b};
    r = 64'd0;
    if ($countones(op) != 1) return 64'd0;
    if (op[OP_MUL])         r = p_uu[63:0];
    else if (op[OP_MULH])   r = p_ss[127:64];
    else if (op[OP_MULHSU]) r = p_su[127:64];
    else if (op[OP_MULHU])  r = p_uu[127:64];
    else if (op[OP_DIV]) begin
      if (b == 0) r = '1; else if (a == MIN64 && b == '1) r = a; else r = sa / sb;
    end else if (op[OP_DIVU]) begin
      if (b == 0) r = '1; else r = a / b;
    end else if (op[OP_REM]) begin
      if (b == 0) r = a; else if (a == MIN64 && b == '1) r = 64'd0; else r = sa % sb;
    end else if (op[OP_REMU]) begin
      if (b == 0) r = a; else r = a % b;
    end else if (op[OP_MULW]) begin
      t = a32 * b32; r = sx32(t);
    end else if (op[OP_DIVW]) begin
      if (b32 == 0) r = '1;
      else if (a32 == 32'h8000_0000 && b32 == 32'hFFFF_FFFF) r = sx32(a32);
      else begin t = sa32 / sb32; r = sx32(t); end
    end else if (op[OP_DIVUW]) begin
      if (b32 == 0) r = '1; else begin t = a32 / b32; r = sx32(t); end
    end else if (op[OP_REMW]) begin
      if (b32 == 0) r = sx32(a32);
      else if (a32 == 32'h8000_0000 && b32 == 32'hFFFF_FFFF) r = 64'd0;
      else begin t = sa32 % sb32; r = sx32(t); end
    end else if (op[OP_REMUW]) begin
      if (b32 == 0) r = sx32(a32); else begin t = a32 % b32; r = sx32(t); end
    end
    return r;
  endfunction

  // Edges after the fire edge until out_valid: bypass cases show the result in the very next cycle (0)
  function automatic int ref_latency(input logic [12:0] op, input logic [63:0] a, input logic [63:0] b);
    logic word, div_like, sdiv, zero, ovf;
    word     = |op[4:0];
    div_like = (|op[8:5]) | (|op[3:0]);
    sdiv     = op[OP_DIV] | op[OP_REM] | op[OP_DIVW] | op[OP_REMW];
    zero     = word ? (b[31:0] == 0) : (b == 0);
    ovf      = word ? (a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF) : (a == MIN64 && b == '1);
    if ($countones(op) != 1) return 0;
    if (div_like && zero)    return 0;
    if (sdiv && ovf)         return 0;
    return word ? 34 : 66;
  endfunction

  function automatic logic [63:0] rnd_val();
    case ($urandom_range(0, 7))
      0:       return 64'd0;
      1:       return '1;
      2:       return MIN64;
      3:       return 64'hFFFF_FFFF_8000_0000;
      4:       return 64'($urandom_range(0, 40));
      5:       return -64'($urandom_range(1, 40));
      6:       return {$urandom, 32'h8000_0000};
      default: return {$urandom, $urandom};
    endcase
  endfunction

  // Present a request from a negedge and return on the edge that accepts it
  task automatic issue(input logic [12:0] op, input logic [63:0] a, input logic [63:0] b);
    int guard = 0;
    while (!in_ready && guard < 300) begin @(negedge clk); guard++; end
    check_eq("in_ready", {63'd0, in_ready}, 64'd1);
    in_op = op; in_src1 = a; in_src2 = b; in_valid = 1'b1;
    @(posedge clk);
  endtask

  task automatic wait_out(output int lat);
    lat = 0;
    @(negedge clk);
    in_valid = 1'b0;
    while (!out_valid && lat < 300) begin @(negedge clk); lat++; end
  endtask

  task automatic drain();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic run_op(input string tag, input logic [12:0] op, input logic [63:0] a, input logic [63:0] b);
    int lat;
    logic [63:0] exp;
    exp = ref_result(op, a, b);
    issue(op, a, b);
    wait_out(lat);
    check_eq({tag, "_res"}, out_result, exp);
    check_eq({tag, "_lat"}, 64'(lat), 64'(ref_latency(op, a, b)));
    drain();
    check_eq({tag, "_drain"}, {63'd0, out_valid}, 64'd0);
  endtask

  task automatic check_idle_outputs(input string tag);
    check_eq({tag, "_rdy"},  {63'd0, in_ready},  64'd1);
    check_eq({tag, "_vld"},  {63'd0, out_valid}, 64'd0);
    check_eq({tag, "_busy"}, {63'd0, busy},      64'd0);
  endtask

  initial begin
    #900_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int lat;
    logic [63:0] exp;
    logic saw;
    logic [12:0] op;
    int idx;

    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_op = '0; in_src1 = '0; in_src2 = '0;
    repeat (3) @(negedge clk);
    check_idle_outputs("reset");
    check_eq("reset_res", out_result, 64'd0);
    rst = 1'b0;

    // multiply family
    run_op("mul",    opv(OP_MUL),    64'd7, -64'd3);
    run_op("mulh",   opv(OP_MULH),   MIN64, 64'd2);
    run_op("mulhu",  opv(OP_MULHU),  MIN64, 64'd2);
    run_op("mulhsu", opv(OP_MULHSU), '1,    64'd2);
    // divide by zero
    run_op("div0",   opv(OP_DIV),    64'd5, 64'd0);
    run_op("rem0",   opv(OP_REM),    64'd5, 64'd0);
    run_op("divuw0", opv(OP_DIVUW),  64'h1_0000_0005, 64'd0);
    // signed overflow and W remainder
    run_op("divovf", opv(OP_DIV),    MIN64, '1);
    run_op("removf", opv(OP_REM),    MIN64, '1);
    run_op("divwov", opv(OP_DIVW),   64'h8000_0000, '1);
    run_op("remw",   opv(OP_REMW),   -64'd7, 64'd2);
    // illegal encodings
    run_op("ill0",   13'd0,          64'd9, 64'd3);
    run_op("ill2",   opv(OP_MUL) | opv(OP_DIV), 64'd9, 64'd3);

    // back-pressure: result and handshake stay frozen while out_ready is low
    exp = ref_result(opv(OP_DIVU), 64'd123456789, 64'd1000);
    issue(opv(OP_DIVU), 64'd123456789, 64'd1000);
    wait_out(lat);
    repeat (10) begin
      @(negedge clk);
      check_eq("bp_res", out_result, exp);
      check_eq("bp_vld", {63'd0, out_valid}, 64'd1);
      check_eq("bp_rdy", {63'd0, in_ready},  64'd0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check_eq("bp_drain_vld", {63'd0, out_valid}, 64'd0);
    check_eq("bp_drain_rdy", {63'd0, in_ready},  64'd1);

    // flush in CALC cycle 20 with a competing request
    issue(opv(OP_MUL), 64'd7, -64'd3);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (20) @(negedge clk);
    flush = 1'b1; in_valid = 1'b1; in_op = opv(OP_MULW); in_src1 = 64'd5; in_src2 = 64'd5;
    #1;
    check_eq("flush_rdy",  {63'd0, in_ready}, 64'd0);
    check_eq("flush_busy", {63'd0, busy},     64'd1);
    @(negedge clk);
    check_eq("flush_idle", {63'd0, busy},      64'd0);
    check_eq("flush_vld",  {63'd0, out_valid}, 64'd0);
    flush = 1'b0; in_valid = 1'b0;
    #1;
    check_eq("flush_rdy_after", {63'd0, in_ready}, 64'd1);
    saw = 1'b0;
    repeat (80) begin @(negedge clk); if (out_valid) saw = 1'b1; end
    check_eq("flush_noresult", {63'd0, saw}, 64'd0);
    run_op("mulw_f", opv(OP_MULW), 64'h7FFF_FFFF, 64'd2);

    // same scenario with reset instead of flush
    issue(opv(OP_MUL), 64'd7, -64'd3);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (20) @(negedge clk);
    rst = 1'b1; in_valid = 1'b1; in_op = opv(OP_MULW);
    @(negedge clk);
    check_idle_outputs("rst_mid");
    check_eq("rst_mid_res", out_result, 64'd0);
    rst = 1'b0; in_valid = 1'b0;
    saw = 1'b0;
    repeat (80) begin @(negedge clk); if (out_valid) saw = 1'b1; end
    check_eq("rst_noresult", {63'd0, saw}, 64'd0);
    run_op("mulw_r", opv(OP_MULW), 64'h7FFF_FFFF, 64'd2);

    // randomized ops, including occasional illegal encodings
    for (int i = 0; i < 80; i++) begin
      idx = $urandom_range(0, 12);
      op  = opv(idx);
      if ($urandom_range(0, 15) == 0)
        op = ($urandom_range(0, 1) == 0) ? 13'd0 : (opv(idx) | opv((idx + 1) % 13));
      run_op("rand", op, rnd_val(), rnd_val());
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
